// File: rtl/rgb_fade_sequencer.sv
// RGB LED palette sequencer: fades the three PWM duties between palette
// colours, updating only at 256-clock PWM frame boundaries.
module rgb_fade_sequencer #(
  parameter int          NUM_COLORS  = 4,
  parameter logic [15:0] STEP_FRAMES = 16'd4,
  parameter logic [15:0] HOLD_FRAMES = 16'd64,
  localparam int         AW          = $clog2(NUM_COLORS)
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          enable,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [23:0]   wr_data,
  output logic [7:0]    duty_r,
  output logic [7:0]    duty_g,
  output logic [7:0]    duty_b,
  output logic [AW-1:0] color_idx,
  output logic          busy,
  output logic          frame_tick
);

  typedef enum logic [1:0] {
    IDLE,
    FADE,
    HOLD
  } state_t;

  state_t        state;
  logic [7:0]    frm_cnt;
  logic [15:0]   step_cnt;
  logic [15:0]   hold_cnt;
  logic [23:0]   palette [NUM_COLORS];
  logic [23:0]   target;
  logic          boundary;
  logic          at_target;
  logic [AW-1:0] next_idx;

  function automatic logic [7:0] step_to(
    input logic [7:0] cur,
    input logic [7:0] tgt
  );
    if (cur < tgt)
      return cur + 8'd1;
    else if (cur > tgt)
      return cur - 8'd1;
    else
      return cur;
  endfunction

  assign boundary = (frm_cnt == 8'hFF);

  // Free-running frame counter, phase-aligned with the pwm counters
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      frm_cnt    <= 8'd0;
      frame_tick <= 1'b0;
    end else begin
      frm_cnt    <= frm_cnt + 8'd1;
      frame_tick <= boundary;
    end
  end

  // Addresses past the last entry match no slot and are dropped
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < NUM_COLORS; i++)
        palette[i] <= 24'd0;
    end else begin
      for (int i = 0; i < NUM_COLORS; i++)
        if (wr_en && wr_addr == AW'(i))
          palette[i] <= wr_data;
    end
  end

  always_comb begin
    target = 24'd0;
    for (int i = 0; i < NUM_COLORS; i++)
      if (color_idx == AW'(i))
        target = palette[i];
  end

  assign at_target = (duty_r == target[23:16]) &&
                     (duty_g == target[15:8]) &&
                     (duty_b == target[7:0]);

  assign next_idx = (color_idx == AW'(NUM_COLORS - 1)) ?
                    '0 : color_idx + 1'b1;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      duty_r    <= 8'd0;
      duty_g    <= 8'd0;
      duty_b    <= 8'd0;
      color_idx <= '0;
      step_cnt  <= 16'd0;
      hold_cnt  <= 16'd0;
    end else if (state != IDLE && !enable) begin
      // Disable does not wait for a frame boundary
      state    <= IDLE;
      busy     <= 1'b0;
      step_cnt <= 16'd0;
      hold_cnt <= 16'd0;
    end else if (boundary) begin
      unique case (state)
        IDLE: begin
          if (enable) begin
            state    <= FADE;
            busy     <= 1'b1;
            step_cnt <= 16'd0;
          end
        end
        FADE: begin
          if (at_target) begin
            state    <= HOLD;
            hold_cnt <= 16'd0;
          end else if (step_cnt == STEP_FRAMES - 16'd1) begin
            step_cnt <= 16'd0;
            duty_r   <= step_to(duty_r, target[23:16]);
            duty_g   <= step_to(duty_g, target[15:8]);
            duty_b   <= step_to(duty_b, target[7:0]);
          end else begin
            step_cnt <= step_cnt + 16'd1;
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_FRAMES - 16'd1) begin
            hold_cnt  <= 16'd0;
            color_idx <= next_idx;
            state     <= FADE;
            step_cnt  <= 16'd0;
          end else begin
            hold_cnt <= hold_cnt + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Bench for rgb_fade_sequencer: frame-level reference model with
// directed steps and random palette edits.
module tb_rgb_fade_sequencer;

  localparam int NC = 3;
  localparam int SF = 2;
  localparam int HF = 2;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          enable = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [23:0]   wr_data = '0;
  logic [7:0]    duty_r;
  logic [7:0]    duty_g;
  logic [7:0]    duty_b;
  logic [AW-1:0] color_idx;
  logic          busy;
  logic          frame_tick;

  rgb_fade_sequencer #(
    .NUM_COLORS (NC),
    .STEP_FRAMES(16'(SF)),
    .HOLD_FRAMES(16'(HF))
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .enable    (enable),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .duty_r    (duty_r),
    .duty_g    (duty_g),
    .duty_b    (duty_b),
    .color_idx (color_idx),
    .busy      (busy),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reference: 0 idle, 1 fading, 2 holding
  int m_st;
  int m_d [3];
  int m_idx;
  int m_step;
  int m_hold;
  int m_pal [NC];

  function automatic int chan(input int col, input int c);
    return (col >> (16 - 8 * c)) & 255;
  endfunction

  task automatic model_reset();
    m_st = 0;
    m_idx = 0;
    m_step = 0;
    m_hold = 0;
    for (int c = 0; c < 3; c++) m_d[c] = 0;
    for (int i = 0; i < NC; i++) m_pal[i] = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cyc %0d)",
             tag, obs, exp, cyc);
    end
  endtask

  task automatic check_all();
    chk("duty_r", 32'(duty_r), 32'(m_d[0]));
    chk("duty_g", 32'(duty_g), 32'(m_d[1]));
    chk("duty_b", 32'(duty_b), 32'(m_d[2]));
    chk("color_idx", 32'(color_idx), 32'(m_idx));
    chk("busy", 32'(busy), 32'(m_st != 0));
    chk("frame_tick", 32'(frame_tick), 32'(cyc > 0 && cyc % 256 == 0));
  endtask

  task automatic model_edge();
    bit eq;
    int t;
    if (m_st != 0 && !enable) begin
      m_st = 0;
      m_step = 0;
      m_hold = 0;
    end else if ((cyc + 1) % 256 == 0) begin
      if (m_st == 0) begin
        if (enable) begin
          m_st = 1;
          m_step = 0;
        end
      end else if (m_st == 1) begin
        eq = 1;
        for (int c = 0; c < 3; c++)
          if (m_d[c] != chan(m_pal[m_idx], c)) eq = 0;
        if (eq) begin
          m_st = 2;
          m_hold = 0;
        end else if (m_step == SF - 1) begin
          m_step = 0;
          for (int c = 0; c < 3; c++) begin
            t = chan(m_pal[m_idx], c);
            if (m_d[c] < t) m_d[c]++;
            else if (m_d[c] > t) m_d[c]--;
          end
        end else begin
          m_step++;
        end
      end else begin
        if (m_hold == HF - 1) begin
          m_hold = 0;
          m_idx = (m_idx + 1) % NC;
          m_st = 1;
          m_step = 0;
        end else begin
          m_hold++;
        end
      end
    end
    if (wr_en && int'(wr_addr) < NC) m_pal[wr_addr] = int'(wr_data);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc % 64 == 0) check_all();
  endtask

  task automatic pal_wr(input int a, input int d);
    wr_en = 1'b1;
    wr_addr = AW'(a);
    wr_data = 24'(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic run(input int frames, input bit rnd_wr);
    for (int k = 0; k < frames * 256; k++) begin
      if (rnd_wr && $urandom_range(0, 199) == 0) begin
        wr_en = 1'b1;
        wr_addr = AW'($urandom_range(0, 3));
        wr_data = 24'($urandom) & 24'h070707;
      end
      tick();
      wr_en = 1'b0;
    end
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    #1;
    chk("rst_duty_r", 32'(duty_r), 0);
    chk("rst_duty_g", 32'(duty_g), 0);
    chk("rst_duty_b", 32'(duty_b), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_idx", 32'(color_idx), 0);
    chk("rst_tick", 32'(frame_tick), 0);
    @(posedge clk);
    #3;
    nrst = 1'b1;
    cyc = 0;
    model_reset();
  endtask

  initial begin
    int guard;
    model_reset();
    #2;
    do_reset();

    // Basic fade, hold, advance and wrap
    pal_wr(0, 24'h030001);
    pal_wr(1, 24'h000200);
    pal_wr(2, 24'h010101);
    pal_wr(3, 24'hFFFFFF);
    enable = 1'b1;
    run(45, 1'b0);

    // Disable mid-fade and resume
    guard = 0;
    while (m_st != 1 && guard < 20 * 256) begin
      tick();
      guard++;
    end
    repeat (300) tick();
    enable = 1'b0;
    tick();
    chk("dis_busy", 32'(busy), 0);
    run(3, 1'b0);
    enable = 1'b1;
    run(12, 1'b0);

    // Reset mid-run: palette cleared, duties stay at zero
    do_reset();
    run(12, 1'b0);

    // Live edit of the current target
    pal_wr(0, 24'h0A0000);
    guard = 0;
    while (duty_r != 8'd5 && guard < 20 * 256) begin
      tick();
      guard++;
    end
    chk("live_r5", 32'(duty_r), 5);
    pal_wr(0, 24'h020000);
    guard = 0;
    while (duty_r != 8'd2 && guard < 10 * 256) begin
      tick();
      guard++;
    end
    chk("live_r2", 32'(duty_r), 2);
    run(10, 1'b0);

    // Random palette edits, including the out-of-range address
    run(50, 1'b1);
    enable = 1'b0;
    tick();
    chk("end_busy", 32'(busy), 0);
    run(2, 1'b1);
    enable = 1'b1;
    run(40, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
